// File: rtl/audio_clk_gen.sv
// I2S clock generator: qualifies the audio PLL lock, then divides the master
// clock into BCLK/LRCLK with single-cycle edge and frame strobes.
module audio_clk_gen #(
  parameter int MCLK_PER_BCLK  = 8,
  parameter int BITS_PER_FRAME = 64,
  parameter int LOCK_HOLDOFF   = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       enable,
  output logic       clk_ready,
  output logic       bclk_out,
  output logic       lrclk_out,
  output logic       bclk_rise_en,
  output logic       bclk_fall_en,
  output logic       frame_start,
  output logic [7:0] lock_loss_cnt
);

  localparam int DW = $clog2(MCLK_PER_BCLK);
  localparam int BW = $clog2(BITS_PER_FRAME);
  localparam int HW = $clog2(LOCK_HOLDOFF + 1);

  localparam logic [DW-1:0] DIV_MAX  = DW'(MCLK_PER_BCLK - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(MCLK_PER_BCLK / 2);
  localparam logic [BW-1:0] BIT_MAX  = BW'(BITS_PER_FRAME - 1);
  localparam logic [BW-1:0] BIT_HALF = BW'(BITS_PER_FRAME / 2);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LOCK_HOLDOFF - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    READY     = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t        state;
  logic [1:0]    lock_sync;
  logic [DW-1:0] div;
  logic [BW-1:0] bit_idx;
  logic [HW-1:0] hold_cnt;

  logic          lk_s;
  logic          last_cycle;
  logic [DW-1:0] div_nxt;
  logic [BW-1:0] bit_nxt;

  assign lk_s       = lock_sync[1];
  assign last_cycle = (div == DIV_MAX) && (bit_idx == BIT_MAX);
  assign div_nxt    = (div == DIV_MAX) ? '0 : div + DW'(1);
  assign bit_nxt    = (div != DIV_MAX) ? bit_idx :
                      (bit_idx == BIT_MAX) ? '0 : bit_idx + BW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_LOCK;
      lock_sync     <= '0;
      div           <= '0;
      bit_idx       <= '0;
      hold_cnt      <= '0;
      clk_ready     <= 1'b0;
      bclk_out      <= 1'b0;
      lrclk_out     <= 1'b0;
      bclk_rise_en  <= 1'b0;
      bclk_fall_en  <= 1'b0;
      frame_start   <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      // NOTE: non-blocking only; the defaults below are overridden later in
      // the same block, which gives "0 unless this branch says otherwise".
      lock_sync    <= {lock_sync[0], pll_locked};
      clk_ready    <= 1'b0;
      bclk_out     <= 1'b0;
      lrclk_out    <= 1'b0;
      bclk_rise_en <= 1'b0;
      bclk_fall_en <= 1'b0;
      frame_start  <= 1'b0;

      if (!lk_s) begin
        state <= WAIT_LOCK;
        if ((state == READY || state == RUN) && lock_loss_cnt != 8'hFF)
          lock_loss_cnt <= lock_loss_cnt + 8'd1;
      end else begin
        unique case (state)
          WAIT_LOCK: begin
            state    <= SETTLE;
            hold_cnt <= '0;
          end
          SETTLE: begin
            if (hold_cnt == HOLD_MAX) begin
              state     <= READY;
              clk_ready <= 1'b1;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          READY: begin
            clk_ready <= 1'b1;
            if (enable) begin
              state        <= RUN;
              div          <= '0;
              bit_idx      <= '0;
              bclk_fall_en <= 1'b1;
              frame_start  <= 1'b1;
            end
          end
          RUN: begin
            clk_ready <= 1'b1;
            // enable only takes effect at a frame boundary
            if (last_cycle && !enable) begin
              state <= READY;
            end else begin
              div          <= div_nxt;
              bit_idx      <= bit_nxt;
              bclk_out     <= (div_nxt >= DIV_HALF);
              bclk_rise_en <= (div_nxt == DIV_HALF);
              bclk_fall_en <= (div_nxt == '0);
              lrclk_out    <= (bit_nxt >= BIT_HALF);
              frame_start  <= (div_nxt == '0) && (bit_nxt == '0);
            end
          end
          default: state <= WAIT_LOCK;
        endcase
      end
    end
  end

endmodule
